// File: rtl/i2c_slave_reg.sv
// SCCB/I2C register-bank responder: oversampled two-wire target with pointer byte and per-byte write strobe.
// Read transactions are compiled in when I2C_SLV_READ_EN is defined.
`timescale 1ns/1ps
module i2c_slave_reg #(
  parameter logic [6:0] DEV_ADDR = 7'h21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i2c_sclk,
  inout  wire logic  i2c_sdat,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEV, S_REG, S_DATA, S_ACK, S_IGNORE, S_TX, S_RXACK
  } state_t;

  state_t     state, state_nxt;
  state_t     ack_next, ack_next_nxt;
  logic       ack_on, ack_on_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] ptr, ptr_nxt;
  logic       sda_oe, sda_oe_nxt;
  logic       busy_nxt;
  logic       wr_pend, wr_pend_nxt;
  logic       wr_en_nxt;
  logic [7:0] wr_addr_nxt, wr_data_nxt;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;
  logic [7:0] byte_in;

`ifdef I2C_SLV_READ_EN
  logic [7:0] tx_sh, tx_sh_nxt;
`else
  logic rd_unused;
  assign rd_unused = ^rd_data;
`endif

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign sda_rise  = sda_s2 & ~sda_d;
  assign sda_fall  = ~sda_s2 & sda_d;
  assign start_det = sda_fall & scl_s2 & scl_d;
  assign stop_det  = sda_rise & scl_s2 & scl_d;
  assign byte_in   = {shreg[6:0], sda_s2};

  assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;
  assign rd_addr  = ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_d    <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_d    <= 1'b1;
      state    <= S_IDLE;
      ack_next <= S_IDLE;
      ack_on   <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
      ptr      <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_pend  <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
`ifdef I2C_SLV_READ_EN
      tx_sh    <= '0;
`endif
    end else begin
      scl_s1   <= i2c_sclk;
      scl_s2   <= scl_s1;
      scl_d    <= scl_s2;
      sda_s1   <= i2c_sdat;
      sda_s2   <= sda_s1;
      sda_d    <= sda_s2;
      state    <= state_nxt;
      ack_next <= ack_next_nxt;
      ack_on   <= ack_on_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      ptr      <= ptr_nxt;
      sda_oe   <= sda_oe_nxt;
      busy     <= busy_nxt;
      wr_pend  <= wr_pend_nxt;
      wr_en    <= wr_en_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
`ifdef I2C_SLV_READ_EN
      tx_sh    <= tx_sh_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    ack_next_nxt = ack_next;
    ack_on_nxt   = ack_on;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    ptr_nxt      = ptr;
    sda_oe_nxt   = sda_oe;
    busy_nxt     = busy;
    wr_pend_nxt  = 1'b0;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
`ifdef I2C_SLV_READ_EN
    tx_sh_nxt    = tx_sh;
`endif

    // A completed data byte is committed one cycle after its last bit, even if a START/STOP follows.
    if (wr_pend) begin
      wr_en_nxt   = 1'b1;
      wr_addr_nxt = ptr;
      wr_data_nxt = shreg;
      ptr_nxt     = ptr + 8'd1;
    end

    if (start_det) begin
      state_nxt   = S_DEV;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      ack_on_nxt  = 1'b0;
    end else if (stop_det) begin
      state_nxt   = S_IDLE;
      sda_oe_nxt  = 1'b0;
      ack_on_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_IGNORE: ;
        S_DEV: begin
          if (scl_rise) begin
            shreg_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack_on_nxt = 1'b0;
              if (byte_in[7:1] == DEV_ADDR && !byte_in[0]) begin
                state_nxt    = S_ACK;
                ack_next_nxt = S_REG;
                busy_nxt     = 1'b1;
              end
`ifdef I2C_SLV_READ_EN
              else if (byte_in[7:1] == DEV_ADDR) begin
                state_nxt    = S_ACK;
                ack_next_nxt = S_TX;
                busy_nxt     = 1'b1;
              end
`endif
              else begin
                state_nxt = S_IGNORE;
              end
            end
          end
        end
        S_REG: begin
          if (scl_rise) begin
            shreg_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr_nxt      = byte_in;
              state_nxt    = S_ACK;
              ack_next_nxt = S_DATA;
              ack_on_nxt   = 1'b0;
            end
          end
        end
        S_DATA: begin
          if (scl_rise) begin
            shreg_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              wr_pend_nxt  = 1'b1;
              state_nxt    = S_ACK;
              ack_next_nxt = S_DATA;
              ack_on_nxt   = 1'b0;
            end
          end
        end
        S_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              sda_oe_nxt = 1'b1;
              ack_on_nxt = 1'b1;
            end else begin
              sda_oe_nxt  = 1'b0;
              ack_on_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = ack_next;
`ifdef I2C_SLV_READ_EN
              if (ack_next == S_TX) begin
                tx_sh_nxt  = {rd_data[6:0], 1'b0};
                sda_oe_nxt = ~rd_data[7];
              end
`endif
            end
          end
        end
`ifdef I2C_SLV_READ_EN
        S_TX: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = S_RXACK;
            end else begin
              sda_oe_nxt  = ~tx_sh[7];
              tx_sh_nxt   = {tx_sh[6:0], 1'b0};
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end
        S_RXACK: begin
          if (scl_rise) begin
            if (sda_s2) begin
              state_nxt = S_IGNORE;
            end else begin
              // Re-enter ACK already in its second half so the next fall loads the following byte.
              ptr_nxt      = ptr + 8'd1;
              state_nxt    = S_ACK;
              ack_next_nxt = S_TX;
              ack_on_nxt   = 1'b1;
            end
          end
        end
`endif
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_reg.sv
// Bench for i2c_slave_reg: bit-banged bus master, table of write transactions, write-strobe scoreboard.
`timescale 1ns/1ps
module tb_i2c_slave_reg;
  localparam int Q = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic       wr_en;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       busy;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);
  assign rd_data = rd_addr ^ 8'h56;

  always #5 clock = ~clock;

  i2c_slave_reg #(.DEV_ADDR(7'h21)) dut (
    .clock(clock), .reset(reset), .i2c_sclk(scl), .i2c_sdat(sda),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;
  logic [7:0]  mptr = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got addr %02h data %02h expected no strobe", wr_addr, wr_data);
      end else begin
        exp_w = exp_q.pop_front();
        chk("wr_strobe", {16'h0, wr_addr, wr_data}, {16'h0, exp_w});
      end
    end
  end

  task automatic start_c();
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic stop_c();
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #(2*Q);
  endtask

  task automatic put_bit(input logic b);
    m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic put_byte(input logic [7:0] b, output logic ack, output logic rel);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; ack = ~sda; #Q; scl = 1'b0; #Q;
    rel = sda;
  endtask

  task automatic get_byte(output logic [7:0] b);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      get_bit(x);
      b[i] = x;
    end
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] reg_a;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
  } vec_t;

  task automatic xfer(input vec_t v);
    logic ack, rel;
    logic [7:0] d;
    start_c();
    put_byte(v.dev, ack, rel);
    chk("dev_ack", ack, v.exp_ack);
    chk("dev_release", rel, 1'b1);
    chk("busy_active", busy, v.exp_ack);
    put_byte(v.reg_a, ack, rel);
    chk("reg_ack", ack, v.exp_ack);
    chk("reg_release", rel, 1'b1);
    if (v.exp_ack) mptr = v.reg_a;
    for (int j = 0; j < v.n; j++) begin
      d = (j == 0) ? v.d0 : v.d1;
      if (v.exp_ack) begin
        exp_q.push_back({mptr, d});
        mptr = mptr + 8'd1;
      end
      put_byte(d, ack, rel);
      chk("data_ack", ack, v.exp_ack);
      chk("data_release", rel, 1'b1);
    end
    stop_c();
    chk("busy_after_stop", busy, 1'b0);
    chk("wr_missing", exp_q.size(), 0);
    chk("rd_addr", rd_addr, mptr);
  endtask

  vec_t tbl[7];

  initial begin
    logic ack, rel;
    logic [7:0] rb;
    vec_t v;

    tbl[0] = '{8'h42, 8'h12, 1, 8'h80, 8'h00, 1'b1};
    tbl[1] = '{8'h60, 8'h12, 1, 8'h80, 8'h00, 1'b0};
    tbl[2] = '{8'h42, 8'h10, 2, 8'hAA, 8'h55, 1'b1};
    tbl[3] = '{8'h42, 8'hFF, 2, 8'h01, 8'h02, 1'b1};
    tbl[4] = '{8'h44, 8'h33, 1, 8'h77, 8'h00, 1'b0};
    tbl[5] = '{8'h40, 8'h44, 1, 8'h12, 8'h00, 1'b0};
    tbl[6] = '{8'h42, 8'h7F, 1, 8'h00, 8'h00, 1'b1};

    #32;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_rd_addr", rd_addr, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sda", sda, 1'b1);
    reset = 1'b1;
    #(4*Q);

    for (int k = 0; k < 7; k++) xfer(tbl[k]);
    chk("wr_hold_addr", wr_addr, 8'h7F);
    chk("wr_hold_data", wr_data, 8'h00);

    // Reset while the device is pulling the ACK low.
    start_c();
    for (int i = 7; i >= 0; i--) put_bit(v_dev_bit(i));
    m_low = 1'b0; #Q;
    chk("ack_drive", sda, 1'b0);
    reset = 1'b0; #1;
    chk("ack_async_release", sda, 1'b1);
    #19; reset = 1'b1; #80;
    scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    stop_c();
    mptr = 8'h00;
    chk("rst_ack_busy", busy, 1'b0);
    chk("rst_ack_ptr", rd_addr, 8'h00);

    // Reset during the 4th bit of a data byte.
    start_c();
    put_byte(8'h42, ack, rel);
    chk("rb_dev_ack", ack, 1'b1);
    put_byte(8'h20, ack, rel);
    chk("rb_reg_ack", ack, 1'b1);
    for (int i = 7; i >= 5; i--) put_bit(rb_bit(8'h3C, i));
    m_low = 1'b0; #Q; scl = 1'b1; #Q;
    reset = 1'b0; #1;
    chk("rb_sda_z", sda, 1'b1);
    #19; reset = 1'b1; #80;
    scl = 1'b0; #Q;
    for (int i = 3; i >= 0; i--) put_bit(rb_bit(8'h3C, i));
    put_bit(1'b1);
    stop_c();
    mptr = 8'h00;
    chk("rb_ptr", rd_addr, 8'h00);
    chk("rb_no_wr", exp_q.size(), 0);
    v = '{8'h42, 8'h05, 1, 8'h3C, 8'h00, 1'b1};
    xfer(v);

    // STOP after five data bits discards the byte.
    start_c();
    put_byte(8'h42, ack, rel);
    chk("sp_dev_ack", ack, 1'b1);
    put_byte(8'h30, ack, rel);
    chk("sp_reg_ack", ack, 1'b1);
    mptr = 8'h30;
    for (int i = 7; i >= 3; i--) put_bit(rb_bit(8'hC3, i));
    stop_c();
    chk("sp_busy", busy, 1'b0);
    chk("sp_ptr", rd_addr, 8'h30);
    v = '{8'h42, 8'h31, 1, 8'h99, 8'h00, 1'b1};
    xfer(v);

    // Pointer write, repeated START, read attempt, master NACK.
    start_c();
    put_byte(8'h42, ack, rel);
    chk("rd_dev_ack", ack, 1'b1);
    put_byte(8'h0A, ack, rel);
    chk("rd_reg_ack", ack, 1'b1);
    mptr = 8'h0A;
    start_c();
    put_byte(8'h43, ack, rel);
`ifdef I2C_SLV_READ_EN
    chk("rd_addr_ack", ack, 1'b1);
    get_byte(rb);
    chk("rd_byte", rb, 8'h5C);
`else
    chk("rd_addr_nack", ack, 1'b0);
    get_byte(rb);
    chk("rd_sda_z", rb, 8'hFF);
`endif
    put_bit(1'b1);
    stop_c();
    chk("rd_ptr", rd_addr, 8'h0A);
    chk("rd_busy", busy, 1'b0);
    chk("rd_no_wr", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic v_dev_bit(input int i);
    logic [7:0] b;
    b = 8'h42;
    return b[i];
  endfunction

  function automatic logic rb_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule

// File: doc/i2c_slave_reg.md
# i2c_slave_reg

SCCB/I2C responder: the target-side counterpart of the camera-configuration write master. It oversamples `i2c_sclk`/`i2c_sdat` on a fast system clock and detects START/STOP. It acknowledges its own 7-bit device address, latches a register-pointer byte, and emits one write strobe per data byte to an external register bank. It sits inside camera-model testbenches and in FPGA designs that expose a configurable register block over the same two-wire bus.

## Interface
- `DEV_ADDR`, 7'h21: 7-bit device address (0x42 write / 0x43 read on the wire).
- `clock`  in  1  system clock; must be ≥16× SCL frequency.
- `reset`  in  1  asynchronous, active-low reset.
- `i2c_sclk`  in  1  bus clock from master (the block never stretches it).
- `i2c_sdat`  inout  1  open-drain data: driven 0 or `z` only.
- `wr_en`  out  1  one-cycle write strobe.
- `wr_addr`  out  8  register address for `wr_en`.
- `wr_data`  out  8  register data for `wr_en`.
- `rd_addr`  out  8  current register pointer (read side).
- `rd_data`  in  8  register contents at `rd_addr`; combinational or stable ≥2 cycles after `rd_addr` changes.
- `busy`  out  1  high from a START that matches `DEV_ADDR` until STOP.

## Operation
- `i2c_sclk` and `i2c_sdat` each pass through a 2-flop synchronizer and then a 1-flop edge detector. `z` reads as 1.
- START: `sdat` falls while `sclk` is high. STOP: `sdat` rises while `sclk` is high. Both override every state.
  - A START in any state, including a repeated START, enters DEV with the bit counter at 0.
  - A STOP goes to IDLE, releases `sdat`, and clears `busy`.
- Bits are sampled on synchronized `sclk` rising edges, MSB first. The block changes its `sdat` drive only on synchronized `sclk` falling edges.
- States and transitions:
  - IDLE: wait for START.
  - DEV: shift 8 bits. Address match with R/W=0 goes to ACK, then REG. Any mismatch goes to IGNORE with no ACK.
  - REG: shift 8 bits into the pointer, then ACK, then DATA.
  - DATA: shift 8 bits. On the 8th rising edge: `wr_en` pulses 1 cycle later with `wr_addr`=pointer and `wr_data`=byte. The pointer then increments, wrapping 0xFF→0x00. Then ACK, then DATA again (burst writes).
  - ACK: drive 0 from the falling edge after bit 8 until the next falling edge, then release.
  - IGNORE: `sdat` released; wait for START or STOP.
- A STOP or START part-way through a byte discards that byte: no `wr_en`, pointer unchanged.
- The pointer persists across transactions until reset.
- Reset values: `i2c_sdat`=z, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0, `busy`=0, state IDLE.

## Timing
- Bus pin edge to internal event: 3 clock cycles.
- SCL high and low phases must each be ≥4 clock cycles. The 20 kHz configuration clock at a 25 MHz `clock` gives a large margin.
- `sdat` setup/hold relative to SCL rising edge: ≥1 clock cycle each, after synchronization.
- `wr_en` asserts 4 cycles after the 8th data-bit SCL rising edge at the pin. `wr_addr`/`wr_data` are held until the next strobe.
- ACK low drive begins ≤4 cycles after the SCL falling edge at the pin.
- A `reset` assertion at any time releases `sdat` asynchronously.

## Configuration
- `I2C_SLV_READ_EN` defined: read transactions are supported.
  - In DEV, a match with R/W=1 is ACKed.
  - `rd_data` is sampled at the falling edge that ends the ACK and shifted out MSB first, one bit per falling edge.
  - After 8 bits, `sdat` is released and the master's ACK is sampled on the 9th rising edge.
  - Master ACK (0): pointer increments and the next byte is sent.
  - Master NACK (1): go to IGNORE.
- `I2C_SLV_READ_EN` undefined: R/W=1 is NACKed and goes to IGNORE. `rd_addr` still tracks the pointer, and `rd_data` is unused.

## Test plan
- Write 0x42, 0x12, 0x80 with STOP at 20 kHz → three ACKs (sdat=0 on each 9th clock), exactly one `wr_en` with `wr_addr`=0x12, `wr_data`=0x80, and `busy` low after STOP.
- Address 0x60, 0x12, 0x80 → `sdat` stays `z` at every 9th clock, no `wr_en`, `busy` stays 0.
- Burst 0x42, 0x10, 0xAA, 0x55 → two `wr_en` strobes: (0x10, 0xAA) then (0x11, 0x55). Pointer 0xFF followed by 2 data bytes → writes to 0xFF then 0x00.
- `reset` pulsed low during the 4th bit of the data byte → `sdat` is `z` within the same cycle and no `wr_en`. The next complete 0x42, 0x05, 0x3C write gives `wr_en` with (0x05, 0x3C).
- STOP inserted after 5 data bits → IDLE, no `wr_en`. The following full transaction is accepted normally.
- Sequence 0x42, 0x0A, Sr, 0x43, `rd_data`=0x5C, master NACK, STOP:
  - With `I2C_SLV_READ_EN`: 0x5C appears on `sdat`, `rd_addr`=0x0A.
  - Without it: 0x43 is NACKed and `sdat` stays `z`.
